// File: rtl/cnn_quant_pkg.sv
// Shared types and limits for the layer requantization path.
// sat_q8 folds a wide signed value into the int8 range.
package cnn_quant_pkg;

  localparam int SHIFT_MAX = 31;
  localparam int INT8_MIN  = -128;
  localparam int INT8_MAX  = 127;
  localparam int Q_ACC_W   = 32;

  typedef logic signed [Q_ACC_W-1:0] acc_t;
  typedef logic signed [7:0]         shift_t;
  typedef logic signed [7:0]         q8_t;

  function automatic q8_t sat_q8(input logic signed [63:0] v);
    q8_t res;
    if (v > 64'(INT8_MAX)) begin
      res = q8_t'(INT8_MAX);
    end else if (v < 64'(INT8_MIN)) begin
      res = q8_t'(INT8_MIN);
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: signed shift with round-half-up on right shifts,
// optional ReLU, then int8 saturation. Shift magnitudes clamp to SHIFT_MAX.
module requant_sat
  import cnn_quant_pkg::*;
(
  input  acc_t   acc,
  input  shift_t shift,
  input  logic   relu_en,
  output q8_t    q
);

  logic [8:0]         s9_s;
  logic [8:0]         mag_s;
  logic [4:0]         amt_s;
  logic signed [32:0] rnd_s;
  logic signed [32:0] sum_s;
  logic signed [32:0] quo_s;
  logic signed [63:0] r_s;
  logic signed [63:0] rr_s;

  // shift/round, ReLU and saturate; right shifts use one guard bit so the rounding add cannot overflow
  always_comb begin
    s9_s  = {shift[7], shift};
    mag_s = s9_s[8] ? (~s9_s + 9'd1) : s9_s;
    amt_s = (mag_s > 9'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : mag_s[4:0];
    rnd_s = 33'sd0;
    sum_s = 33'sd0;
    quo_s = 33'sd0;
    if (s9_s[8]) begin
      r_s = {{32{acc[31]}}, acc} <<< amt_s;
    end else if (mag_s != 9'd0) begin
      rnd_s = 33'sd1 <<< (amt_s - 5'd1);
      sum_s = {acc[31], acc} + rnd_s;
      quo_s = sum_s >>> amt_s;
      r_s   = {{31{quo_s[32]}}, quo_s};
    end else begin
      r_s = {{32{acc[31]}}, acc};
    end
    rr_s = (relu_en && r_s[63]) ? 64'sd0 : r_s;
    q    = sat_q8(rr_s);
  end

endmodule

// File: rtl/requant_shift_stage_dp3.sv
// Layer-3 requantization stage: channel counter drives the shift ROM, a capture
// stage samples acc+shift, and an output stage holds the int8 result on valid/ready.
module requant_shift_stage_dp3
  import cnn_quant_pkg::*;
#(
  parameter int NUM_CH  = 128,
  parameter int CH_W    = 7,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ch_clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_acc,
  output logic [CH_W-1:0]         rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_last
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic            en_s;
  logic            accept_s;
  logic [CH_W-1:0] addr_s;
  logic [CH_W-1:0] ch_cnt_r;
  logic            v1_r;
  acc_t            acc1_r;
  shift_t          sh1_r;
  logic [CH_W-1:0] ch1_r;
  q8_t             q_s;

  // a clear on the same cycle as a beat tags that beat as channel 0
  assign en_s     = ~out_valid | out_ready;
  assign in_ready = en_s;
  assign accept_s = in_valid & en_s;
  assign addr_s   = ch_clear ? '0 : ch_cnt_r;
  assign rom_addr = addr_s;

  requant_sat u_sat (
    .acc     (acc1_r),
    .shift   (sh1_r),
    .relu_en (RELU_EN),
    .q       (q_s)
  );

  // channel counter: advances per accepted beat, wraps at the last channel
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_r <= '0;
    end else if (accept_s) begin
      ch_cnt_r <= (addr_s == LAST_CH) ? '0 : addr_s + CH_W'(1);
    end else if (ch_clear) begin
      ch_cnt_r <= '0;
    end else begin
      ch_cnt_r <= ch_cnt_r;
    end
  end

  // two-stage pipeline advancing only on the global enable
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      acc1_r    <= '0;
      sh1_r     <= '0;
      ch1_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (en_s) begin
      v1_r      <= in_valid;
      out_valid <= v1_r;
      if (accept_s) begin
        acc1_r <= in_acc;
        sh1_r  <= rom_data;
        ch1_r  <= addr_s;
      end
      if (v1_r) begin
        out_data <= q_s;
        out_ch   <= ch1_r;
        out_last <= (ch1_r == LAST_CH);
      end
    end
  end

endmodule
